stopwatch_timer: RTL

STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

---
 rtl/stopwatch_timer_pkg.sv | 7 +
 rtl/stopwatch_timer_digit_counter.sv | 23 ++
 rtl/stopwatch_timer.sv | 90 +++++++++
 3 files changed

// File: rtl/stopwatch_timer_pkg.sv
// stopwatch_timer_pkg: shared state encoding and BCD digit constants
package stopwatch_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;
  localparam int DIGIT_W = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX = 9;
endpackage

// File: rtl/stopwatch_timer_digit_counter.sv
// digit_counter: one BCD digit counting 0..MAX up or down, with synchronous load
module digit_counter import stopwatch_timer_pkg::*; #(
  parameter int MAX = DIGIT_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               down,
  input  logic               load,
  input  logic [DIGIT_W-1:0] value,
  output logic [DIGIT_W-1:0] q,
  output logic               carry_out,
  output logic               borrow_out
);
  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MAX);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (load) q <= value;
    else if (en) q <= down ? (q == '0 ? TOP : q - 1'b1) : (q == TOP ? '0 : q + 1'b1);
  // terminal-count flags: the next enable rolls this digit over
  assign carry_out = ~down & (q == TOP);
  assign borrow_out = down & (q == '0);
endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: mm:ss.cc stopwatch / countdown timer with pause, lap freeze and alarm
module stopwatch_timer import stopwatch_timer_pkg::*; #(
  parameter int DIV = 500_000,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start_Stop,
  input  logic        Clear,
  input  logic        Load,
  input  logic [7:0]  D,
  input  logic        Down,
  input  logic        Lap,
  output logic [23:0] Digits,
  output logic        Running,
  output logic        Alarm,
  output logic        Wrap
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [DIGIT_W-1:0] TENS_TOP = DIGIT_W'(MIN_TENS_MAX);
  localparam logic [DIGIT_W-1:0] UNITS_TOP = DIGIT_W'(DIGIT_MAX);
  state_t state, next;
  logic mode, frz, tick, expire, ld, ss, lap;
  logic [PW-1:0] presc;
  logic [5:0] en, cy, bw;
  logic [DIGIT_W-1:0] q [6];
  logic [DIGIT_W-1:0] tens, units;
  logic [23:0] live, snap;
  assign live = {q[5], q[4], q[3], q[2], q[1], q[0]};
  assign ld = Load & ~Clear & (state == IDLE | state == PAUSED);
  assign ss = Start_Stop & ~Clear & ~Load;
  assign lap = Lap & ~Clear & ~Load & ~Start_Stop & (state == RUNNING);
  assign tick = (state == RUNNING) & (presc == LAST);
  // counting down from 00:00.01 (or already at zero) ends the run
  assign expire = tick & (&bw[5:1]) & (q[0] <= DIGIT_W'(1));
  assign tens = Clear ? '0 : D[7:4] > TENS_TOP ? TENS_TOP : D[7:4];
  assign units = Clear ? '0 : D[3:0] > UNITS_TOP ? UNITS_TOP : D[3:0];
  assign Digits = frz ? snap : live;
  always_comb begin
    logic c;
    c = tick & ~(&bw);
    for (int k = 0; k < 6; k++) begin
      en[k] = c;
      c = c & (cy[k] | bw[k]);
    end
  end
  always_comb begin
    next = state;
    if (Clear) next = IDLE;
    else if (expire) next = EXPIRED;
    else if (ss)
      next = state == IDLE ? ((Down && live == '0) ? EXPIRED : RUNNING) :
             state == RUNNING ? PAUSED : state == PAUSED ? RUNNING : IDLE;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      mode <= 1'b0;
      frz <= 1'b0;
      snap <= '0;
      presc <= '0;
      Running <= 1'b0;
      Alarm <= 1'b0;
      Wrap <= 1'b0;
    end else begin
      state <= next;
      Running <= next == RUNNING;
      Alarm <= next == EXPIRED;
      Wrap <= en[5] & cy[5] & ~Clear;
      if (state == IDLE && next == RUNNING) mode <= Down;
      presc <= (Clear | ld | tick | next == IDLE) ? '0 :
               (state == RUNNING && next == RUNNING) ? presc + 1'b1 : presc;
      frz <= (Clear | next == IDLE) ? 1'b0 : frz ^ lap;
      if (lap & ~frz) snap <= live;
    end
  for (genvar i = 0; i < 6; i++) begin : g_digit
    digit_counter #(.MAX(i == 5 ? MIN_TENS_MAX : i == 3 ? SEC_TENS_MAX : DIGIT_MAX)) u_digit (
      .clk(Clock),
      .rst(Reset),
      .en(en[i]),
      .down(mode),
      .load(Clear | ld),
      .value(i == 5 ? tens : i == 4 ? units : '0),
      .q(q[i]),
      .carry_out(cy[i]),
      .borrow_out(bw[i])
    );
  end
endmodule
